// File: rtl/alu_opfetch.sv
// Operand-fetch stage in front of the ALU. It reads a register file with write-back bypass and
// holds one instruction under a valid/ready handshake. Bypassing also applies to held operands while stalled.
module alu_opfetch #(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_inst,
  output logic        in_ready,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a,
  output logic [31:0] d,
  output logic [31:0] inf,
  output logic [15:0] stall_cnt
);

  function automatic logic signed [31:0] sext13(input logic signed [12:0] v);
    logic signed [31:0] r;
    r = v;
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic in_range(input logic [4:0] idx);
    return {27'd0, idx} < 32'(NREGS);
  endfunction

  logic [31:0] r_rf [NREGS];

  logic        r_vld_p1;
  logic [31:0] r_a_p1;
  logic [31:0] r_d_p1;
  logic [31:0] r_inf_p1;
  logic [4:0]  r_rs1_p1;
  logic [4:0]  r_rs2_p1;
  logic        r_imm_p1;
  logic [15:0] r_stall_cnt;

  logic [4:0]         w_rs1;
  logic [4:0]         w_rs2;
  logic               w_imm;
  logic signed [31:0] w_simm;
  logic               w_wb_we;
  logic               w_accept;
  logic               w_stall;
  logic [31:0]        w_rs1_val;
  logic [31:0]        w_rs2_val;
  logic               w_hold_a;
  logic               w_hold_d;

  assign w_rs1   = in_inst[18:14];
  assign w_rs2   = in_inst[4:0];
  assign w_imm   = in_inst[13];
  assign w_simm  = sext13(in_inst[12:0]);
  // A write-back is only real if it lands in the file; bypass uses the same qualifier so both agree.
  assign w_wb_we = wb_en && (wb_addr != 5'd0) && in_range(wb_addr);

  assign in_ready = !r_vld_p1 || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_stall  = r_vld_p1 && !out_ready;
  assign w_hold_a = w_stall && w_wb_we && (wb_addr == r_rs1_p1);
  assign w_hold_d = w_stall && w_wb_we && !r_imm_p1 && (wb_addr == r_rs2_p1);

  always_comb begin
    w_rs1_val = 32'd0;
    w_rs2_val = 32'd0;
    if (w_wb_we && (wb_addr == w_rs1))
      w_rs1_val = wb_data;
    else if ((w_rs1 != 5'd0) && in_range(w_rs1))
      w_rs1_val = r_rf[w_rs1];
    if (w_wb_we && (wb_addr == w_rs2))
      w_rs2_val = wb_data;
    else if ((w_rs2 != 5'd0) && in_range(w_rs2))
      w_rs2_val = r_rf[w_rs2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) r_rf[k] <= 32'd0;
    end else if (w_wb_we) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  // Stage p1: operand/instruction holding register presented to the ALU
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1    <= 1'b0;
      r_a_p1      <= 32'd0;
      r_d_p1      <= 32'd0;
      r_inf_p1    <= 32'd0;
      r_rs1_p1    <= 5'd0;
      r_rs2_p1    <= 5'd0;
      r_imm_p1    <= 1'b0;
      r_stall_cnt <= 16'd0;
    end else begin
      if (w_stall) r_stall_cnt <= sat_inc16(r_stall_cnt);
      if (w_accept) begin
        r_vld_p1 <= 1'b1;
        r_a_p1   <= w_rs1_val;
        r_d_p1   <= w_imm ? w_simm : w_rs2_val;
        r_inf_p1 <= in_inst;
        r_rs1_p1 <= w_rs1;
        r_rs2_p1 <= w_rs2;
        r_imm_p1 <= w_imm;
      end else if (r_vld_p1 && out_ready) begin
        r_vld_p1 <= 1'b0;
      end else begin
        if (w_hold_a) r_a_p1 <= wb_data;
        if (w_hold_d) r_d_p1 <= wb_data;
      end
    end
  end

  assign out_valid = r_vld_p1;
  assign a         = r_a_p1;
  assign d         = r_d_p1;
  assign inf       = r_inf_p1;
  assign stall_cnt = r_stall_cnt;

endmodule
